// File: rtl/sig_ext_pkg.sv
// Shared definitions for the decode-stage immediate extender: mode encoding,
// default widths and the reference extension function.
package sig_ext_pkg;

  typedef enum logic [1:0] {
    EXT_SIGN   = 2'd0,
    EXT_ZERO   = 2'd1,
    EXT_UPPER  = 2'd2,
    EXT_BRANCH = 2'd3
  } ext_sel_e;

  localparam int IMM_W  = 16;
  localparam int WORD_W = 32;

  // Branch offsets are word-aligned: the sign-extended value moves up two bits
  // and its top two bits fall off, with no saturation.
  function automatic logic [WORD_W-1:0] extend(input ext_sel_e sel,
                                               input logic [IMM_W-1:0] imm);
    logic [WORD_W-1:0] sx;
    sx = {{(WORD_W-IMM_W){imm[IMM_W-1]}}, imm};
    case (sel)
      EXT_ZERO:   extend = {{(WORD_W-IMM_W){1'b0}}, imm};
      EXT_UPPER:  extend = {imm, {(WORD_W-IMM_W){1'b0}}};
      EXT_BRANCH: extend = {sx[WORD_W-3:0], 2'b00};
      default:    extend = sx;
    endcase
  endfunction

endpackage

// File: rtl/sig_ext16_32.sv
// Immediate extender: zero-latency sign extension plus a registered,
// mode-selectable extension that feeds the ALU operand mux.
module sig_ext16_32
  import sig_ext_pkg::*;
#(
  parameter int IN_W  = IMM_W,
  parameter int OUT_W = WORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  input_data,
  output logic [OUT_W-1:0] output_data,
  output logic             is_neg,
  input  logic [1:0]       ext_sel,
  input  logic             in_valid,
  output logic [OUT_W-1:0] out_data_q,
  output logic             out_valid,
  output logic             out_neg_q
);

  if (IN_W < 2 || OUT_W < IN_W + 2) begin : g_bad_widths
    $error("sig_ext16_32: need IN_W >= 2 and OUT_W >= IN_W + 2");
  end

  // Touches only input_data, so undriven control pins cannot disturb it.
  assign output_data = {{(OUT_W-IN_W){input_data[IN_W-1]}}, input_data};
  assign is_neg      = input_data[IN_W-1];

  logic [OUT_W-1:0] ext_next;

  if (IN_W == IMM_W && OUT_W == WORD_W) begin : g_pkg_extend
    assign ext_next = extend(ext_sel_e'(ext_sel), input_data);
  end else begin : g_local_extend
    always_comb begin
      // NOTE: default assignment first so every path drives ext_next -- no latch.
      ext_next = output_data;
      case (ext_sel_e'(ext_sel))
        EXT_ZERO:   ext_next = {{(OUT_W-IN_W){1'b0}}, input_data};
        EXT_UPPER:  ext_next = {input_data, {(OUT_W-IN_W){1'b0}}};
        EXT_BRANCH: ext_next = {output_data[OUT_W-3:0], 2'b00};
        default:    ext_next = output_data;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state so every register samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      out_data_q <= '0;
      out_valid  <= 1'b0;
      out_neg_q  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      // Data and sign hold on idle cycles; only the valid flag drops.
      if (in_valid) begin
        out_data_q <= ext_next;
        out_neg_q  <= input_data[IN_W-1];
      end
    end
  end

endmodule

// File: tb/tb_sig_ext16_32.sv
// Directed bench for sig_ext16_32: combinational sweep, modes, hold,
// mid-stream reset and back-to-back streaming against hand-computed values.
module tb_sig_ext16_32;
  import sig_ext_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] input_data;
  logic [31:0] output_data;
  logic        is_neg;
  logic [1:0]  ext_sel;
  logic        in_valid;
  logic [31:0] out_data_q;
  logic        out_valid;
  logic        out_neg_q;

  int n_cmp  = 0;
  int n_fail = 0;

  sig_ext16_32 dut (
    .clk        (clk),
    .rst        (rst),
    .input_data (input_data),
    .output_data(output_data),
    .is_neg     (is_neg),
    .ext_sel    (ext_sel),
    .in_valid   (in_valid),
    .out_data_q (out_data_q),
    .out_valid  (out_valid),
    .out_neg_q  (out_neg_q)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_comb_sweep();
    logic [15:0] vin  [5] = '{16'h7FFF, 16'h8000, 16'hFFFE, 16'h0001, 16'hFFFF};
    logic [31:0] vout [5] = '{32'h0000_7FFF, 32'hFFFF_8000, 32'hFFFF_FFFE,
                              32'h0000_0001, 32'hFFFF_FFFF};
    logic        vneg [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      input_data = vin[i];
      #1;
      n_cmp++;
      if (output_data !== vout[i]) begin
        n_fail++;
        $display("FAIL comb_data[%0d]: got %h, want %h", i, output_data, vout[i]);
      end
      n_cmp++;
      if (is_neg !== vneg[i]) begin
        n_fail++;
        $display("FAIL comb_neg[%0d]: got %b, want %b", i, is_neg, vneg[i]);
      end
    end
  endtask

  task automatic test_comb_random();
    logic [15:0] v;
    for (int i = 0; i < 6; i++) begin
      v = 16'($urandom);
      input_data = v;
      #1;
      n_cmp++;
      if (output_data[15:0] !== v || output_data[31:16] !== {16{v[15]}}) begin
        n_fail++;
        $display("FAIL rand_data[%0d]: in %h got %h", i, v, output_data);
      end
      n_cmp++;
      if ($signed(output_data) != $signed(v)) begin
        n_fail++;
        $display("FAIL rand_signed[%0d]: in %h got %h", i, v, output_data);
      end
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    ext_sel  = EXT_SIGN;
    step();
    n_cmp++;
    if (out_valid !== 1'b0 || out_data_q !== 32'h0 || out_neg_q !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: got v=%b d=%h n=%b, want v=0 d=00000000 n=0",
               out_valid, out_data_q, out_neg_q);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_modes();
    logic [15:0] vin  [5] = '{16'h8000, 16'h1234, 16'hFFFF, 16'h4000, 16'h8001};
    ext_sel_e    vsel [5] = '{EXT_ZERO, EXT_UPPER, EXT_BRANCH, EXT_BRANCH, EXT_SIGN};
    logic [31:0] vout [5] = '{32'h0000_8000, 32'h1234_0000, 32'hFFFF_FFFC,
                              32'h0001_0000, 32'hFFFF_8001};
    logic        vneg [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      input_data = vin[i];
      ext_sel    = vsel[i];
      in_valid   = 1'b1;
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data_q !== vout[i] || out_neg_q !== vneg[i]) begin
        n_fail++;
        $display("FAIL mode[%0d]: got v=%b d=%h n=%b, want v=1 d=%h n=%b",
                 i, out_valid, out_data_q, out_neg_q, vout[i], vneg[i]);
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_hold();
    input_data = 16'h00FF;
    ext_sel    = EXT_SIGN;
    in_valid   = 1'b1;
    step();
    n_cmp++;
    if (out_valid !== 1'b1 || out_data_q !== 32'h0000_00FF) begin
      n_fail++;
      $display("FAIL hold_load: got v=%b d=%h, want v=1 d=000000ff",
               out_valid, out_data_q);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      input_data = 16'h9000 + 16'(i);
      ext_sel    = 2'(i + 1);
      step();
      n_cmp++;
      if (out_valid !== 1'b0 || out_data_q !== 32'h0000_00FF || out_neg_q !== 1'b0) begin
        n_fail++;
        $display("FAIL hold[%0d]: got v=%b d=%h n=%b, want v=0 d=000000ff n=0",
                 i, out_valid, out_data_q, out_neg_q);
      end
    end
  endtask

  task automatic test_reset_midstream();
    input_data = 16'h1111;
    ext_sel    = EXT_SIGN;
    in_valid   = 1'b1;
    step();
    input_data = 16'h8000;
    rst        = 1'b1;
    step();
    n_cmp++;
    if (out_valid !== 1'b0 || out_data_q !== 32'h0 || out_neg_q !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got v=%b d=%h n=%b, want v=0 d=00000000 n=0",
               out_valid, out_data_q, out_neg_q);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_idle: got v=%b, want v=0", out_valid);
    end
    input_data = 16'h8000;
    ext_sel    = EXT_ZERO;
    in_valid   = 1'b1;
    step();
    n_cmp++;
    if (out_valid !== 1'b1 || out_data_q !== 32'h0000_8000 || out_neg_q !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_resume: got v=%b d=%h n=%b, want v=1 d=00008000 n=1",
               out_valid, out_data_q, out_neg_q);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [15:0] vin  [8] = '{16'h0001, 16'hFFFF, 16'h8000, 16'h0001,
                              16'h8000, 16'h7FFF, 16'hABCD, 16'hC000};
    ext_sel_e    vsel [8] = '{EXT_SIGN, EXT_ZERO, EXT_UPPER, EXT_BRANCH,
                              EXT_BRANCH, EXT_BRANCH, EXT_SIGN, EXT_BRANCH};
    logic [31:0] vout [8] = '{32'h0000_0001, 32'h0000_FFFF, 32'h8000_0000, 32'h0000_0004,
                              32'hFFFE_0000, 32'h0001_FFFC, 32'hFFFF_ABCD, 32'hFFFF_0000};
    logic        vneg [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      input_data = vin[i];
      ext_sel    = vsel[i];
      in_valid   = 1'b1;
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data_q !== vout[i] || out_neg_q !== vneg[i]) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got v=%b d=%h n=%b, want v=1 d=%h n=%b",
                 i, out_valid, out_data_q, out_neg_q, vout[i], vneg[i]);
      end
    end
    in_valid = 1'b0;
    step();
    n_cmp++;
    if (out_valid !== 1'b0 || out_data_q !== 32'hFFFF_0000) begin
      n_fail++;
      $display("FAIL b2b_drain: got v=%b d=%h, want v=0 d=ffff0000",
               out_valid, out_data_q);
    end
  endtask

  initial begin
    test_comb_sweep();
    test_comb_random();
    test_reset();
    test_modes();
    test_hold();
    test_reset_midstream();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
